// File: rtl/chunk_adder_pkg.sv
// chunk_adder_pkg: shared definitions for the chunked multi-cycle adder.
//   state_t       - FSM state encoding (IDLE, RUN, DONE)
//   chunk_cfg_ok  - elaboration-time check that WIDTH is a whole number of CHUNKs
package chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic bit chunk_cfg_ok(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_adder_if.sv
// chunk_adder_if: operand/result handshake bundle for chunk_adder.
//   in_valid/in_ready   - operand handshake (A, B, Cin, and sub when
//                         CHUNK_ADDER_SUB_EN is defined)
//   out_valid/out_ready - result handshake (S, Cout)
// Modports: master = producer/consumer side, slave = the adder.
interface chunk_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
`ifdef CHUNK_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;

  modport master (
    output in_valid, A, B, Cin,
`ifdef CHUNK_ADDER_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, S, Cout
  );

  modport slave (
    input  in_valid, A, B, Cin,
`ifdef CHUNK_ADDER_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, S, Cout
  );
endinterface

// File: rtl/chunk_add_slice.sv
// chunk_add_slice: combinational CHUNK-bit ripple-carry adder.
//   a, b : CHUNK-bit addends
//   ci   : carry in
//   s    : CHUNK-bit sum
//   co   : carry out of the top bit
module chunk_add_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  logic c;

  always_comb begin
    c = ci;
    s = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

// File: rtl/chunk_adder.sv
// chunk_adder: multi-cycle adder computing {Cout,S} = A + B + Cin, CHUNK bits
// per clock, with valid/ready handshakes on operand and result sides.
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - chunk_adder_if.slave: in_valid/in_ready/A/B/Cin(/sub),
//          out_valid/out_ready/S/Cout
// Optional feature: CHUNK_ADDER_SUB_EN adds the sub input; sub=1 computes
// A - B (Cout=1 means no borrow), Cin ignored.
// Latency NCHUNK edges from accept to out_valid; WIDTH must equal the
// interface WIDTH and be a multiple of CHUNK.
module chunk_adder
  import chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic          clk,
  input  logic          rst,
  chunk_adder_if.slave  bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             carry_q, cout_q;

  logic [CHUNK-1:0] sl_s;
  logic             sl_co;
  logic             accept, running, last;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef CHUNK_ADDER_SUB_EN
  // Subtraction as A + ~B + 1.
  assign b_load = bus.sub ? ~bus.B : bus.B;
  assign c_load = bus.sub ? 1'b1 : bus.Cin;
`else
  assign b_load = bus.B;
  assign c_load = bus.Cin;
`endif

  assign accept  = (state_q == IDLE) && bus.in_valid;
  assign running = (state_q == RUN);
  assign last    = running && (k_q == K_LAST);

  chunk_add_slice #(.CHUNK(CHUNK)) u_slice (
    .a  (a_q[CHUNK-1:0]),
    .b  (b_q[CHUNK-1:0]),
    .ci (carry_q),
    .s  (sl_s),
    .co (sl_co)
  );

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        if (k_q == K_LAST) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      k_q     <= '0;
      a_q     <= bus.A;
      b_q     <= b_load;
      carry_q <= c_load;
    end else if (running) begin
      // Concatenate-then-shift keeps CHUNK == WIDTH legal (no empty slice).
      s_q     <= WIDTH'({sl_s, s_q} >> CHUNK);
      a_q     <= a_q >> CHUNK;
      b_q     <= b_q >> CHUNK;
      carry_q <= sl_co;
      k_q     <= k_q + 1'b1;
      if (last) cout_q <= sl_co;
    end
  end

  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
endmodule

// File: tb/tb_chunk_adder.sv
// tb_chunk_adder: self-checking bench for chunk_adder (WIDTH=16, CHUNK=4)
// plus a CHUNK=16 instance for the single-cycle configuration.
// Subtraction vectors are included when CHUNK_ADDER_SUB_EN is defined.
module tb_chunk_adder;
  localparam int unsigned W  = 16;
  localparam int unsigned C  = 4;
  localparam int unsigned NC = W / C;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chunk_adder_if #(.WIDTH(W)) ifa ();
  chunk_adder_if #(.WIDTH(W)) ifb ();

  chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  chunk_adder #(.WIDTH(W), .CHUNK(W)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  typedef struct {
    logic [15:0] s;
    logic        cout;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    string       name;
  } vec_t;

  res_t sb_q[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare at the negedge before each result handshake edge.
  always @(negedge clk) begin
    res_t e;
    if (rst === 1'b0 && ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got S=%0h with no result expected", ifa.S);
      end else begin
        e = sb_q.pop_front();
        check("sb_S", {16'h0, ifa.S}, {16'h0, e.s});
        check("sb_Cout", {31'h0, ifa.Cout}, {31'h0, e.cout});
      end
    end
  end

  task automatic do_op(input vec_t v);
    int n;
    int lat;
    n = 0;
    while (ifa.in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({v.name, "_in_ready"}, {31'h0, ifa.in_ready}, 32'h1);
    ifa.A   = v.a;
    ifa.B   = v.b;
    ifa.Cin = v.cin;
`ifdef CHUNK_ADDER_SUB_EN
    ifa.sub = v.sub;
`endif
    ifa.in_valid = 1'b1;
    sb_q.push_back('{s: v.s, cout: v.cout});
    tick();
    ifa.in_valid = 1'b0;
    ifa.A   = 16'($urandom);
    ifa.B   = 16'($urandom);
    ifa.Cin = 1'($urandom);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (ifa.out_valid !== 1'b1 && lat < 50);
    check({v.name, "_latency"}, lat, NC);
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    check({v.name, "_idle"}, {30'h0, ifa.out_valid, ifa.in_ready}, 32'h1);
    check({v.name, "_S_hold"}, {16'h0, ifa.S}, {16'h0, v.s});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b1;
    ifa.in_valid = 1'b0; ifa.A = '0; ifa.B = '0; ifa.Cin = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.A = '0; ifb.B = '0; ifb.Cin = 1'b0; ifb.out_ready = 1'b0;
`ifdef CHUNK_ADDER_SUB_EN
    ifa.sub = 1'b0;
    ifb.sub = 1'b0;
`endif
    tick();
    tick();
    check("rst_in_ready", {31'h0, ifa.in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, ifa.out_valid}, 32'h0);
    check("rst_S", {16'h0, ifa.S}, 32'h0);
    check("rst_Cout", {31'h0, ifa.Cout}, 32'h0);
    rst = 1'b0;
    tick();

    vecs.push_back('{a: 16'h0003, b: 16'h0004, cin: 1'b0, sub: 1'b0, s: 16'h0007, cout: 1'b0, name: "add_3_4"});
    vecs.push_back('{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sub: 1'b0, s: 16'h0000, cout: 1'b1, name: "add_ripple"});
    vecs.push_back('{a: 16'h8000, b: 16'h8000, cin: 1'b1, sub: 1'b0, s: 16'h0001, cout: 1'b1, name: "add_msb_cin"});
    vecs.push_back('{a: 16'h1234, b: 16'h4321, cin: 1'b1, sub: 1'b0, s: 16'h5556, cout: 1'b0, name: "add_mixed"});
    vecs.push_back('{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sub: 1'b0, s: 16'hFFFF, cout: 1'b1, name: "add_max"});
    vecs.push_back('{a: 16'h0000, b: 16'h0000, cin: 1'b1, sub: 1'b0, s: 16'h0001, cout: 1'b0, name: "add_cin_only"});
    vecs.push_back('{a: 16'hABCD, b: 16'h1111, cin: 1'b0, sub: 1'b0, s: 16'hBCDE, cout: 1'b0, name: "add_abcd"});
`ifdef CHUNK_ADDER_SUB_EN
    vecs.push_back('{a: 16'h0005, b: 16'h0009, cin: 1'b0, sub: 1'b1, s: 16'hFFFC, cout: 1'b0, name: "sub_5_9"});
    vecs.push_back('{a: 16'h0009, b: 16'h0005, cin: 1'b0, sub: 1'b1, s: 16'h0004, cout: 1'b1, name: "sub_9_5"});
    vecs.push_back('{a: 16'h0009, b: 16'h0005, cin: 1'b1, sub: 1'b1, s: 16'h0004, cout: 1'b1, name: "sub_cin_ignored"});
    vecs.push_back('{a: 16'h0007, b: 16'h0007, cin: 1'b0, sub: 1'b1, s: 16'h0000, cout: 1'b1, name: "sub_equal"});
    vecs.push_back('{a: 16'h0009, b: 16'h0005, cin: 1'b0, sub: 1'b0, s: 16'h000E, cout: 1'b0, name: "sub0_adds"});
`endif
    foreach (vecs[i]) do_op(vecs[i]);

    // Result held in DONE while the consumer stalls; in_valid pulse ignored.
`ifdef CHUNK_ADDER_SUB_EN
    ifa.sub = 1'b0;
`endif
    ifa.A = 16'h00FF; ifa.B = 16'h0F01; ifa.Cin = 1'b0; ifa.in_valid = 1'b1;
    sb_q.push_back('{s: 16'h1000, cout: 1'b0});
    tick();
    ifa.in_valid = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (ifa.out_valid !== 1'b1 && lat < 50);
    check("stall_latency", lat, NC);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", {31'h0, ifa.out_valid}, 32'h1);
      check("stall_S", {16'h0, ifa.S}, 32'h1000);
      check("stall_Cout", {31'h0, ifa.Cout}, 32'h0);
      check("stall_in_ready", {31'h0, ifa.in_ready}, 32'h0);
      if (i == 2) begin
        ifa.in_valid = 1'b1;
        ifa.A = 16'h7777;
        ifa.B = 16'h1111;
      end else begin
        ifa.in_valid = 1'b0;
      end
      tick();
    end
    ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    check("stall_idle", {30'h0, ifa.out_valid, ifa.in_ready}, 32'h1);
    repeat (6) tick();
    check("stall_no_ghost", {31'h0, ifa.out_valid}, 32'h0);
    check("stall_sb_empty", sb_q.size(), 0);

    // Asynchronous reset while RUN is at k=2.
    ifa.A = 16'h1111; ifa.B = 16'h2222; ifa.Cin = 1'b0; ifa.in_valid = 1'b1;
    sb_q.push_back('{s: 16'h3333, cout: 1'b0});
    tick();
    ifa.in_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'h0, ifa.out_valid}, 32'h0);
    check("arst_S", {16'h0, ifa.S}, 32'h0);
    check("arst_Cout", {31'h0, ifa.Cout}, 32'h0);
    check("arst_in_ready", {31'h0, ifa.in_ready}, 32'h1);
    sb_q.delete();
    tick();
    rst = 1'b0;
    tick();
    check("arst_post_idle", {30'h0, ifa.out_valid, ifa.in_ready}, 32'h1);
    do_op('{a: 16'd10, b: 16'd10, cin: 1'b0, sub: 1'b0, s: 16'd20, cout: 1'b0, name: "after_rst"});

    // CHUNK=WIDTH instance: single-cycle latency.
    ifb.A = 16'hFFFF; ifb.B = 16'h0001; ifb.Cin = 1'b0; ifb.in_valid = 1'b1;
    tick();
    ifb.in_valid = 1'b0;
    check("w_not_early", {31'h0, ifb.out_valid}, 32'h0);
    tick();
    check("w_out_valid", {31'h0, ifb.out_valid}, 32'h1);
    check("w_S", {16'h0, ifb.S}, 32'h0);
    check("w_Cout", {31'h0, ifb.Cout}, 32'h1);
    ifb.out_ready = 1'b1;
    tick();
    ifb.out_ready = 1'b0;
    check("w_idle", {30'h0, ifb.out_valid, ifb.in_ready}, 32'h1);
`ifdef CHUNK_ADDER_SUB_EN
    ifb.A = 16'd9; ifb.B = 16'd5; ifb.Cin = 1'b0; ifb.sub = 1'b1; ifb.in_valid = 1'b1;
    tick();
    ifb.in_valid = 1'b0;
    tick();
    check("w_sub_out_valid", {31'h0, ifb.out_valid}, 32'h1);
    check("w_sub_S", {16'h0, ifb.S}, 32'h4);
    check("w_sub_Cout", {31'h0, ifb.Cout}, 32'h1);
    ifb.out_ready = 1'b1;
    tick();
    ifb.out_ready = 1'b0;
`endif

    check("final_sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/chunk_adder.md
# chunk_adder

Parametrised multi-cycle adder: adds two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register, behind valid/ready handshakes on both sides. Generalises the fixed 4-bit combinational adder into a reusable arithmetic unit for datapaths where area matters more than latency. It sits between an operand producer and a result consumer, either of which may stall.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; NCHUNK = WIDTH/CHUNK.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in.
- sub  input  1  subtract select; present only with CHUNK_ADDER_SUB_EN.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- S  output  WIDTH  sum.
- Cout  output  1  carry out of bit WIDTH-1.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: chunk index k = 0..NCHUNK-1.
  - DONE: out_valid=1.
- IDLE, in_valid&in_ready at an edge:
  - Capture A, B and Cin into the operand shift registers and the carry register.
  - Set k=0 and go to RUN.
- RUN, each cycle:
  - Add the low CHUNK bits of A, the low CHUNK bits of B, and the carry.
  - Shift the CHUNK-bit result into S from the MSB end.
  - Shift both operands right by CHUNK.
  - Store the chunk carry-out in the carry register.
  - Increment k.
- RUN, when k = NCHUNK-1: go to DONE at that edge; Cout takes the final carry.
- DONE:
  - S and Cout stay stable until out_valid&out_ready.
  - On that handshake, go to IDLE.
  - S and Cout keep their last values after the handshake.
- Arithmetic: {Cout,S} = A + B + Cin, modulo 2^(WIDTH+1). No overflow flag.
- in_valid outside IDLE is ignored; the operand inputs are not sampled.
- A, B and Cin may change freely after the accept edge.

## Timing
- Reset (asynchronous, any state): state=IDLE, in_ready=1, out_valid=0, S=0, Cout=0, carry=0. Any in-flight operation is discarded with no result.
- Latency: out_valid rises NCHUNK edges after the accept edge.
- Best-case issue interval, with out_ready held high: NCHUNK+2 cycles.
  - Accept edge.
  - NCHUNK RUN edges.
  - Output-handshake edge.
  - One IDLE cycle.
- out_valid never drops without a handshake; the next accept is never earlier than the cycle after a handshake.
- CHUNK=WIDTH is legal:
  - NCHUNK=1, latency 1.
  - k is a 1-value counter.

## Configuration
- CHUNK_ADDER_SUB_EN defined:
  - The `sub` port exists.
  - If sub=1 at the accept edge, B is captured inverted and the carry register is loaded with 1; Cin is ignored.
  - Result is A-B modulo 2^WIDTH; Cout=1 means no borrow (A>=B unsigned).
  - sub=0 behaves exactly as the undefined case.
- CHUNK_ADDER_SUB_EN undefined: no `sub` port; add only.

## Structure
- Shared package `chunk_adder_pkg`:
  - State enum typedef (IDLE, RUN, DONE).
  - Elaboration-time check helper for WIDTH % CHUNK == 0.
- One sub-module, `chunk_add_slice`:
  - Combinational CHUNK-bit ripple adder: a, b, ci -> s, co.
  - Instantiated once in the top level.
- Top level holds:
  - FSM and k counter.
  - Operand shift registers.
  - Carry register.
  - Result register.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated.
- A=3, B=4, Cin=0 -> S=7, Cout=0; out_valid high exactly 4 edges after the accept edge.
- A=16'hFFFF, B=16'h0001, Cin=0 -> S=0, Cout=1; carry propagates across all four chunks.
- A=16'h8000, B=16'h8000, Cin=1 -> S=16'h0001, Cout=1.
- out_ready low for 5 cycles in DONE:
  - out_valid, S and Cout held stable; in_ready=0.
  - A pulse on in_valid is ignored.
  - Raise out_ready -> one handshake, then IDLE.
- rst asserted mid-edge during RUN k=2:
  - out_valid=0, S=0, in_ready=1 immediately, without waiting for a clock.
  - Next operation 10+10 -> S=20, Cout=0.
- CHUNK_ADDER_SUB_EN:
  - 5-9 -> S=16'hFFFC, Cout=0.
  - 9-5 -> S=4, Cout=1.
  - Rerun with CHUNK=16: 9-5 gives the same result, latency 1.
